// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM of a multicycle MIPS-style datapath.
// Define CTRL_ADDI_EN to add the ADDIEX/ADDIWB states for opcode 001000.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [1:0] aluOP,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   illegal_nxt;

    // Moore output table; unlisted and unused states drive all zeros.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read = 1'b1;
                c.ir_write = 1'b1;
                c.src_b    = 2'b01;
                c.pc_write = 1'b1;
            end
            DECODE: c.src_b = 2'b11;
            MEMADR: begin
                c.src_a = 1'b1;
                c.src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            REX: begin
                c.src_a  = 1'b1;
                c.alu_op = 2'b10;
            end
            RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BEQ: begin
                c.src_a         = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'b01;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
`ifdef CTRL_ADDI_EN
            ADDIEX: begin
                c.src_a = 1'b1;
                c.src_b = 2'b10;
            end
            ADDIWB: c.reg_write = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_nxt   = FETCH;
        illegal_nxt = 1'b0;
        case (state_q)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = REX;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_J:         state_nxt = JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = ADDIEX;
`endif
                    default: begin
                        state_nxt   = FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            MEMADR: state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            REX:    state_nxt = RWB;
`ifdef CTRL_ADDI_EN
            ADDIEX: state_nxt = ADDIWB;
`endif
            default: state_nxt = FETCH;
        endcase
    end

    // State, registered Moore outputs and the illegal-opcode pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            ctrl_q     <= decode(FETCH);
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ctrl_q     <= decode(state_nxt);
            illegal_op <= illegal_nxt;
        end
    end

    assign state      = state_q;
    assign aluOP      = ctrl_q.alu_op;
    assign alu_src_a  = ctrl_q.src_a;
    assign alu_src_b  = ctrl_q.src_b;
    assign pc_source  = ctrl_q.pc_src;
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign pc_en      = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table vectors, corner sequences and randomized
// instruction streams against an instruction-level reference model.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic [1:0] aluOP;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] state;
    logic       illegal_op;

    int checks   = 0;
    int failures = 0;
    logic exp_ill = 1'b0;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .aluOP      (aluOP),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .state      (state),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]      op;
        logic            z;
        int              len;
        logic [0:5][3:0] seq;
    } vec_t;

    vec_t vecs[11];

    wire [13:0] vis = {aluOP, alu_src_a, alu_src_b, pc_source, i_or_d,
                       mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write};

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected visible outputs per state:
    // {aluOP, src_a, src_b, pc_source, i_or_d, mem_read, mem_write,
    //  ir_write, reg_dst, mem_to_reg, reg_write}, plus pc_write/cond.
    function automatic logic [13:0] exp_vis(input logic [3:0] s,
                                            output logic pw,
                                            output logic pwc);
        logic [13:0] v;
        pw = 1'b0;
        pwc = 1'b0;
        v = '0;
        case (s)
            4'd0: begin
                v = {2'b00, 1'b0, 2'b01, 2'b00, 7'b0101000};
                pw = 1'b1;
            end
            4'd1: v = {2'b00, 1'b0, 2'b11, 2'b00, 7'b0000000};
            4'd2: v = {2'b00, 1'b1, 2'b10, 2'b00, 7'b0000000};
            4'd3: v = {2'b00, 1'b0, 2'b00, 2'b00, 7'b1100000};
            4'd4: v = {2'b00, 1'b0, 2'b00, 2'b00, 7'b0000011};
            4'd5: v = {2'b00, 1'b0, 2'b00, 2'b00, 7'b1010000};
            4'd6: v = {2'b10, 1'b1, 2'b00, 2'b00, 7'b0000000};
            4'd7: v = {2'b00, 1'b0, 2'b00, 2'b00, 7'b0000101};
            4'd8: begin
                v = {2'b01, 1'b1, 2'b00, 2'b01, 7'b0000000};
                pwc = 1'b1;
            end
            4'd9: begin
                v = {2'b00, 1'b0, 2'b00, 2'b10, 7'b0000000};
                pw = 1'b1;
            end
`ifdef CTRL_ADDI_EN
            4'd10: v = {2'b00, 1'b1, 2'b10, 2'b00, 7'b0000000};
            4'd11: v = {2'b00, 1'b0, 2'b00, 2'b00, 7'b0000001};
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic legal(input logic [5:0] op);
        logic ok;
        ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b000010);
`ifdef CTRL_ADDI_EN
        ok = ok || (op == 6'b001000);
`endif
        return ok;
    endfunction

    // Instruction-level model: state walk of one instruction from FETCH.
    function automatic int seq_for(input logic [5:0] op,
                                   output logic [0:5][3:0] s);
        s = '0;
        s[1] = 4'd1;
        case (op)
            6'b100011: begin s[2] = 4'd2; s[3] = 4'd3; s[4] = 4'd4; return 5; end
            6'b101011: begin s[2] = 4'd2; s[3] = 4'd5; return 4; end
            6'b000000: begin s[2] = 4'd6; s[3] = 4'd7; return 4; end
            6'b000100: begin s[2] = 4'd8; return 3; end
            6'b000010: begin s[2] = 4'd9; return 3; end
`ifdef CTRL_ADDI_EN
            6'b001000: begin s[2] = 4'd10; s[3] = 4'd11; return 4; end
`endif
            default: return 2;
        endcase
    endfunction

    // Walk one instruction starting in FETCH, checking every cycle.
    task automatic run_instr(input logic [5:0] op, input logic zv,
                             input bit rnd, input int len,
                             input logic [0:5][3:0] seq);
        logic [13:0] ev;
        logic pw;
        logic pwc;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            if (!rnd || seq[i] == 4'd1 || seq[i] == 4'd2)
                opcode = op;
            else
                opcode = 6'($urandom);
            zero = rnd ? 1'($urandom) : zv;
            #1;
            ev = exp_vis(seq[i], pw, pwc);
            check("state", 16'(state), 16'(seq[i]));
            check("outs", 16'(vis), 16'(ev));
            check("pc_en", 16'(pc_en), 16'(pw | (pwc & zero)));
            check("illegal_op", 16'(illegal_op),
                  16'((i == 0) ? exp_ill : 1'b0));
        end
        exp_ill = !legal(op);
        @(posedge clk);
        #2;
    endtask

    task automatic step_check(input string name, input logic [3:0] s);
        @(posedge clk);
        #2;
        check(name, 16'(state), 16'(s));
    endtask

    initial begin
        logic [0:5][3:0] sq;
        logic [5:0] op;
        int n;
        logic [13:0] ev;
        logic pw;
        logic pwc;

        vecs[0]  = '{6'b100011, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}};
        vecs[1]  = '{6'b101011, 1'b1, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}};
        vecs[2]  = '{6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}};
        vecs[3]  = '{6'b000100, 1'b1, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}};
        vecs[4]  = '{6'b000100, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}};
        vecs[5]  = '{6'b000010, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}};
        vecs[6]  = '{6'b111111, 1'b1, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
        vecs[7]  = '{6'b100011, 1'b1, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}};
`ifdef CTRL_ADDI_EN
        vecs[8]  = '{6'b001000, 1'b0, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0}};
`else
        vecs[8]  = '{6'b001000, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
`endif
        vecs[9]  = '{6'b000001, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
        vecs[10] = '{6'b000000, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}};

        rst = 1'b1;
        opcode = 6'b000000;
        zero = 1'b0;
        #8;
        opcode = 6'b111111;
        #4;
        ev = exp_vis(4'd0, pw, pwc);
        check("reset_state", 16'(state), 16'd0);
        check("reset_outs", 16'(vis), 16'(ev));
        check("reset_illegal", 16'(illegal_op), 16'd0);
        check("reset_pc_en", 16'(pc_en), 16'd1);
        rst = 1'b0;

        foreach (vecs[k])
            run_instr(vecs[k].op, vecs[k].z, 1'b0, vecs[k].len, vecs[k].seq);

        // DECODE sees LW but MEMADR sees SW: the store path is taken.
        opcode = 6'b100011;
        #1;
        check("split_fetch", 16'(state), 16'd0);
        check("split_ill", 16'(illegal_op), 16'(exp_ill));
        step_check("split_decode", 4'd1);
        step_check("split_memadr", 4'd2);
        opcode = 6'b101011;
        step_check("split_memwr", 4'd5);
        step_check("split_fetch2", 4'd0);
        exp_ill = 1'b0;

        // Reset in the middle of an LW, in MEMRD.
        opcode = 6'b100011;
        step_check("lw_decode", 4'd1);
        step_check("lw_memadr", 4'd2);
        step_check("lw_memrd", 4'd3);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_state", 16'(state), 16'd0);
        check("async_rst_strobes", 16'({mem_read, ir_write, i_or_d}), 16'b110);
        check("async_rst_ill", 16'(illegal_op), 16'd0);
        step_check("rst_hold", 4'd0);
        rst = 1'b0;
        opcode = 6'b000010;
        step_check("rel_decode", 4'd1);
        step_check("rel_jump", 4'd9);
        step_check("rel_fetch", 4'd0);

        // Reset on top of an illegal_op pulse clears it at once.
        n = seq_for(6'b111110, sq);
        run_instr(6'b111110, 1'b0, 1'b0, n, sq);
        #1;
        check("ill_pulse", 16'(illegal_op), 16'd1);
        rst = 1'b1;
        #1;
        check("ill_rst", 16'(illegal_op), 16'd0);
        rst = 1'b0;
        exp_ill = 1'b0;

        // Randomized instruction stream against the model.
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            n = seq_for(op, sq);
            run_instr(op, 1'b0, 1'b1, n, sq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
